// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-deep FIFO and its read-side burst controller.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RESP  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_timeout_counter.sv
// Up-counter of consecutive empty-FIFO cycles; expired marks the cycle whose
// increment would bring the count to TIMEOUT.
module timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (en && count != TOP) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a burst of words from the FIFO read port, one single-cycle rd_en at a
// time, and hands each word to the consumer over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// WAIT  | waiting for the FIFO to be non-empty, timeout counter running
// ISSUE | fifo_rd_en high for one cycle
// RESP  | FIFO read data valid, captured into m_data
// HOLD  | m_valid high until the consumer takes the word
module fifo_burst_reader #(
  parameter int DATA_W  = fifo_pkg::DATA_W,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_d_out,
  input  logic              fifo_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [LEN_W-1:0]  words_left
);

  import fifo_pkg::*;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FIFO_DEPTH);

  state_t     state;
  logic       to_en;
  logic       to_clr;
  logic       to_expired;
  logic [LEN_W-1:0] len_sat;

  assign len_sat = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
  assign to_en   = (state == ST_WAIT) && fifo_empty;
  assign to_clr  = !to_en;

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      fifo_rd_en  <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      words_left  <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            timeout_err <= 1'b0;
            if (burst_len != '0) begin
              words_left <= len_sat;
              state      <= ST_WAIT;
              busy       <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            state      <= ST_ISSUE;
          end else if (to_expired) begin
            // words_left deliberately keeps the undelivered count
            timeout_err <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          m_data  <= fifo_d_out;
          m_valid <= 1'b1;
          state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (words_left != '0) begin
              words_left <= words_left - LEN_W'(1);
            end
            if (words_left == LEN_W'(1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model, randomized bursts and
// consumer stalls, checked against an expected-word queue.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  burst_len = '0;
  logic        fifo_rd_en;
  logic [31:0] fifo_d_out = '0;
  logic        fifo_empty = 1'b1;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [3:0]  words_left;

  fifo_burst_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .burst_len   (burst_len),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_d_out  (fifo_d_out),
    .fifo_empty  (fifo_empty),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .words_left  (words_left)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] fq[$];
  logic [31:0] ref_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_w[$];
  logic        pop_pending = 1'b0;

  int  ready_mode = 0;
  int  cyc = 0, rd_cnt = 0, done_cnt = 0, viol = 0, hold_cnt = 0;
  int  hs_cyc = 0, done_cyc = 0;
  bit  prev_rd = 0, prev_wait = 0;
  logic [31:0] prev_data = '0;
  int  exp_eff = 0, exp_deliv = 0;

  // FIFO model: data appears the cycle after rd_en and is zero otherwise
  always @(posedge clk) begin
    logic [31:0] w;
    w = '0;
    if (pop_pending && fq.size() > 0) w = fq.pop_front();
    fifo_d_out <= w;
    fifo_empty <= (fq.size() == 0);
  end

  // consumer driver and protocol monitor
  always @(negedge clk) begin
    bit hs;
    cyc++;
    pop_pending = fifo_rd_en;
    if (fifo_rd_en) rd_cnt++;
    if (fifo_rd_en && prev_rd) viol++;
    if (fifo_rd_en && m_valid) viol++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (prev_wait && (!m_valid || m_data !== prev_data)) viol++;
    if (m_valid) hold_cnt++; else hold_cnt = 0;
    case (ready_mode)
      1:       m_ready = 1'($urandom_range(0, 1));
      2:       m_ready = (hold_cnt > 5);
      default: m_ready = 1'b1;
    endcase
    hs = m_valid && m_ready;
    if (hs) begin got_q.push_back(m_data); hs_cyc = cyc; end
    prev_wait = m_valid && !hs;
    prev_data = m_data;
    prev_rd   = fifo_rd_en;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic preload(input int n, input bit seq, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      logic [31:0] v;
      v = seq ? base + 32'(i) : $urandom;
      fq.push_back(v);
      ref_q.push_back(v);
    end
    tick();
    tick();
  endtask

  task automatic start_burst(input int len);
    exp_eff   = (len > 8) ? 8 : len;
    exp_deliv = (exp_eff < ref_q.size()) ? exp_eff : ref_q.size();
    exp_w.delete();
    for (int i = 0; i < exp_deliv; i++) exp_w.push_back(ref_q.pop_front());
    rd_cnt = 0; done_cnt = 0; viol = 0;
    got_q.delete();
    burst_len = 4'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_burst(input string tag);
    int guard;
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin tick(); guard++; end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    tick();
    tick();
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_rd_cnt"}, rd_cnt, exp_deliv);
    chk({tag, "_words_left"}, 32'(words_left), exp_eff - exp_deliv);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(exp_eff > exp_deliv));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_protocol"}, viol, 0);
    chk({tag, "_n_words"}, got_q.size(), exp_deliv);
    for (int i = 0; i < exp_deliv && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_w[i]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_words_left"}, 32'(words_left), 0);
  endtask

  initial begin
    int guard;
    // reset
    reset_n = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // in-order burst of four with latency checks
    ready_mode = 0;
    preload(4, 1, 32'hA0);
    start_burst(4);
    chk("lat_busy", 32'(busy), 1);
    chk("lat_rd_c1", 32'(fifo_rd_en), 0);
    tick();
    chk("lat_rd_c2", 32'(fifo_rd_en), 1);
    tick();
    chk("lat_valid_c3", 32'(m_valid), 0);
    tick();
    chk("lat_valid_c4", 32'(m_valid), 1);
    chk("lat_data_c4", m_data, 32'hA0);
    end_burst("seq4");

    // consumer backpressure
    ready_mode = 2;
    preload(2, 0, 0);
    start_burst(2);
    end_burst("bp2");

    // zero length: done on the next cycle, nothing read
    ready_mode = 1;
    start_burst(0);
    chk("len0_done_next", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    end_burst("len0");

    // oversize length saturates to the FIFO depth
    preload(8, 0, 0);
    start_burst(12);
    end_burst("len12");
    chk("len12_fifo_empty", fq.size(), 0);

    // underrun: one word delivered then TIMEOUT empty WAIT cycles
    ready_mode = 0;
    preload(1, 0, 0);
    start_burst(3);
    end_burst("underrun");
    chk("underrun_gap", done_cyc - hs_cyc, 16);

    // start during HOLD is ignored
    ready_mode = 2;
    preload(3, 0, 0);
    start_burst(3);
    guard = 0;
    while (!m_valid && guard < 50) begin tick(); guard++; end
    chk("hold_reached", 32'(m_valid), 1);
    burst_len = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_start_wl", 32'(words_left), 3);
    chk("hold_start_busy", 32'(busy), 1);
    end_burst("hold_start");

    // reset during RESP abandons the burst silently
    ready_mode = 0;
    preload(2, 0, 0);
    start_burst(2);
    guard = 0;
    while (!fifo_rd_en && guard < 50) begin tick(); guard++; end
    chk("rst_issue_seen", 32'(fifo_rd_en), 1);
    tick();
    reset_n = 1'b0;
    tick();
    chk_all_zero("rst_resp");
    reset_n = 1'b1;
    ref_q.push_front(exp_w[1]);
    tick(); tick(); tick();
    chk("rst_no_done", done_cnt, 0);
    start_burst(1);
    end_burst("rst_after");

    // randomized bursts, occasional underrun
    for (int n = 0; n < 8; n++) begin
      ready_mode = 1;
      preload($urandom_range(0, 8 - fq.size()), 0, 0);
      start_burst($urandom_range(1, 15));
      end_burst($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench timeout");
  end

endmodule
